// File: rtl/fmap_collector.sv
// Ping-pong feature-map collector: gathers N*N pixel frames into two banks and serves them to a reader.
// Optional build macro FMAP_COLLECTOR_RELU_EN clamps negative pixels to zero on write.
module fmap_collector #(
   parameter int unsigned MAX_SIDE = 32
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [8:0]  image_size,
   input  logic        po_data_valid,
   input  logic [15:0] po_data,
   input  logic        frame_valid,
   input  logic        rd_en,
   input  logic [9:0]  rd_addr,
   input  logic        rd_done,
   output logic [15:0] rd_data,
   output logic        rd_data_valid,
   output logic        frame_ready,
   output logic        overflow,
   output logic        frame_err
);

   localparam int unsigned DEPTH = MAX_SIDE * MAX_SIDE;
   localparam int unsigned AW    = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;
   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_t;

   state_t          state_q, state_d;
   bank_t           bank_q [2];
   bank_t           bank_d [2];
   logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [AW-1:0]   count_q, count_d, last_q, last_d;
   logic [15:0]     rd_data_q, rd_data_d;
   logic            rd_valid_q, rd_valid_d, ready_q, ready_d;
   logic            ovf_q, ovf_d, err_q, err_d;

   logic            mem_we_c, close_c, release_c, size_bad_c;
   logic [AW-1:0]   mem_addr_c, new_last_c;
   logic [15:0]     wdata_c;
   logic [17:0]     size_sq_c;
   logic [15:0]     mem [2][DEPTH];

`ifdef FMAP_COLLECTOR_RELU_EN
   assign wdata_c = po_data[15] ? 16'd0 : po_data;
`else
   assign wdata_c = po_data;
`endif

   // Write FSM, bank bookkeeping and read path next-state logic
   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      count_d    = count_q;
      last_d     = last_q;
      ovf_d      = 1'b0;
      err_d      = 1'b0;
      mem_we_c   = 1'b0;
      mem_addr_c = count_q;
      close_c    = 1'b0;
      size_sq_c  = 18'(image_size) * 18'(image_size);
      new_last_c = AW'(size_sq_c - 18'd1);
      size_bad_c = (image_size == 9'd0) || (image_size > 9'(MAX_SIDE));

      case (state_q)
         S_IDLE: begin
            if (po_data_valid) begin
               if (bank_q[wr_bank_q] != B_EMPTY) begin
                  ovf_d = 1'b1;
                  if (!frame_valid) state_d = S_DROP;
               end else if (size_bad_c) begin
                  err_d = 1'b1;
                  if (!frame_valid) state_d = S_DROP;
               end else begin
                  mem_we_c          = 1'b1;
                  mem_addr_c        = '0;
                  last_d            = new_last_c;
                  bank_d[wr_bank_q] = B_FILLING;
                  if (frame_valid) begin
                     close_c = 1'b1;
                     err_d   = (new_last_c != AW'(0));
                  end else if (new_last_c == AW'(0)) begin
                     close_c = 1'b1;
                     err_d   = 1'b1;
                     state_d = S_DROP;
                  end else begin
                     count_d = AW'(1);
                     state_d = S_WRITE;
                  end
               end
            end
         end
         S_WRITE: begin
            if (po_data_valid) begin
               mem_we_c = 1'b1;
               if (frame_valid) begin
                  close_c = 1'b1;
                  err_d   = (count_q != last_q);
                  state_d = S_IDLE;
               end else if (count_q == last_q) begin
                  close_c = 1'b1;
                  err_d   = 1'b1;
                  state_d = S_DROP;
               end else begin
                  count_d = count_q + AW'(1);
               end
            end
         end
         S_DROP: begin
            if (po_data_valid) begin
               ovf_d = 1'b1;
               if (frame_valid) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (close_c) begin
         bank_d[wr_bank_q] = B_FULL;
         wr_bank_d         = ~wr_bank_q;
         count_d           = '0;
      end

      // Close and release always touch different banks, so both can land together
      release_c = rd_done && ready_q;
      if (release_c) begin
         bank_d[rd_bank_q] = B_EMPTY;
         rd_bank_d         = ~rd_bank_q;
      end
      ready_d = (bank_d[rd_bank_d] == B_FULL);

      rd_valid_d = rd_en && ready_q;
      rd_data_d  = rd_data_q;
      if (rd_valid_d) rd_data_d = mem[rd_bank_q][AW'(rd_addr)];
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_IDLE;
         bank_q[0]  <= B_EMPTY;
         bank_q[1]  <= B_EMPTY;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         count_q    <= '0;
         last_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ready_q    <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         count_q    <= count_d;
         last_q     <= last_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ready_q    <= ready_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
      end
   end

   // Bank storage has no reset; contents are only trusted once a bank is FULL
   always_ff @(posedge sys_clk) begin
      if (mem_we_c) mem[wr_bank_q][mem_addr_c] <= wdata_c;
   end

   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_valid_q;
   assign frame_ready   = ready_q;
   assign overflow      = ovf_q;
   assign frame_err     = err_q;

endmodule

// File: tb/tb_fmap_collector.sv
// Directed bench for fmap_collector: read-vector table plus hand-written multi-cycle frame sequences.
module tb_fmap_collector;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [8:0]  image_size;
   logic        po_data_valid;
   logic [15:0] po_data;
   logic        frame_valid;
   logic        rd_en;
   logic [9:0]  rd_addr;
   logic        rd_done;
   logic [15:0] rd_data;
   logic        rd_data_valid;
   logic        frame_ready;
   logic        overflow;
   logic        frame_err;

   int n_cmp = 0;
   int n_err = 0;
   int ovf_cnt = 0;
   int err_cnt = 0;

   typedef struct {
      logic        en;
      int          addr;
      logic        exp_v;
      logic [15:0] exp_d;
   } rd_vec_t;
   rd_vec_t tbl [6];

   fmap_collector #(.MAX_SIDE(32)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .image_size(image_size),
      .po_data_valid(po_data_valid), .po_data(po_data), .frame_valid(frame_valid),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
      .rd_data_valid(rd_data_valid), .frame_ready(frame_ready),
      .overflow(overflow), .frame_err(frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge sys_clk);
      #1;
      if (overflow === 1'b1) ovf_cnt++;
      if (frame_err === 1'b1) err_cnt++;
   endtask

   task automatic clr();
      ovf_cnt = 0;
      err_cnt = 0;
   endtask

   task automatic pix(input int d, input logic fv, input logic done);
      po_data_valid = 1'b1;
      po_data       = 16'(d);
      frame_valid   = fv;
      rd_done       = done;
      cyc();
      po_data_valid = 1'b0;
      frame_valid   = 1'b0;
      rd_done       = 1'b0;
   endtask

   task automatic frame(input int n, input int cnt, input int base, input int fv_at);
      image_size = 9'(n);
      for (int i = 1; i <= cnt; i++) pix(base + i, (i == fv_at), 1'b0);
   endtask

   task automatic chk_rd(input string name, input int a, input logic [15:0] exp);
      rd_en   = 1'b1;
      rd_addr = 10'(a);
      cyc();
      rd_en = 1'b0;
      chk({name, "_valid"}, 32'(rd_data_valid), 32'd1);
      chk(name, 32'(rd_data), 32'(exp));
   endtask

   task automatic release_bank();
      rd_done = 1'b1;
      cyc();
      rd_done = 1'b0;
   endtask

   task automatic chk_outs_zero(input string name);
      chk({name, "_rd_data"}, 32'(rd_data), 32'd0);
      chk({name, "_rd_valid"}, 32'(rd_data_valid), 32'd0);
      chk({name, "_ready"}, 32'(frame_ready), 32'd0);
      chk({name, "_ovf"}, 32'(overflow), 32'd0);
      chk({name, "_err"}, 32'(frame_err), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] neg_exp;
      tbl[0] = '{1'b1, 0,  1'b1, 16'd1};
      tbl[1] = '{1'b1, 24, 1'b1, 16'd25};
      tbl[2] = '{1'b0, 3,  1'b0, 16'd0};
      tbl[3] = '{1'b1, 12, 1'b1, 16'd13};
      tbl[4] = '{1'b1, 7,  1'b1, 16'd8};
      tbl[5] = '{1'b1, 5,  1'b1, 16'd6};

      sys_rst_n = 1'b0; image_size = 9'd0; po_data_valid = 1'b0; po_data = 16'd0;
      frame_valid = 1'b0; rd_en = 1'b0; rd_addr = 10'd0; rd_done = 1'b0;
      cyc(); cyc();
      chk_outs_zero("reset");
      sys_rst_n = 1'b1;
      cyc();

      // Clean N=5 frame into bank 0
      clr();
      frame(5, 24, 0, 0);
      chk("ready_before_close", 32'(frame_ready), 32'd0);
      pix(25, 1'b1, 1'b0);
      chk("ready_after_close", 32'(frame_ready), 32'd1);
      chk("clean_err_cnt", 32'(err_cnt), 32'd0);
      chk("clean_ovf_cnt", 32'(ovf_cnt), 32'd0);

      for (int i = 0; i < 6; i++) begin
         rd_en   = tbl[i].en;
         rd_addr = 10'(tbl[i].addr);
         cyc();
         rd_en = 1'b0;
         chk($sformatf("tbl%0d_valid", i), 32'(rd_data_valid), 32'(tbl[i].exp_v));
         if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].exp_d));
      end
      for (int a = 0; a < 25; a++) chk_rd($sformatf("sweep%0d", a), a, 16'(a + 1));

      // Second frame fills bank 1, third frame has nowhere to go
      clr();
      frame(5, 25, 100, 25);
      chk("frameB_ovf", 32'(ovf_cnt), 32'd0);
      clr();
      frame(5, 25, 200, 25);
      chk("frameC_ovf", 32'(ovf_cnt), 32'd25);
      chk("frameC_err", 32'(err_cnt), 32'd0);
      chk_rd("bank0_still_A", 3, 16'd4);
      release_bank();
      chk("ready_bank1", 32'(frame_ready), 32'd1);
      chk_rd("bank1_B", 3, 16'd104);
      release_bank();
      chk("ready_both_empty", 32'(frame_ready), 32'd0);
      rd_en = 1'b1; rd_addr = 10'd0;
      cyc();
      rd_en = 1'b0;
      chk("rd_not_ready_valid", 32'(rd_data_valid), 32'd0);

      // Early frame_valid on pixel 20
      clr();
      frame(5, 20, 300, 20);
      chk("short_err", 32'(err_cnt), 32'd1);
      chk("short_ready", 32'(frame_ready), 32'd1);
      chk_rd("short_a0", 0, 16'd301);
      chk_rd("short_a19", 19, 16'd320);
      frame(5, 25, 400, 25);
      release_bank();
      chk_rd("after_short_a0", 0, 16'd401);
      chk_rd("after_short_a24", 24, 16'd425);
      release_bank();

      // Release in the same cycle as the second frame closes
      frame(5, 25, 500, 25);
      image_size = 9'd5;
      for (int i = 1; i <= 25; i++) pix(600 + i, (i == 25), (i == 25));
      chk("simul_ready", 32'(frame_ready), 32'd1);
      chk_rd("simul_bank1", 0, 16'd601);
      clr();
      frame(5, 25, 700, 25);
      chk("bank0_reclaimed_ovf", 32'(ovf_cnt), 32'd0);
      release_bank();
      chk_rd("bank0_new", 0, 16'd701);
      chk_rd("bank0_new_last", 24, 16'd725);
      release_bank();

      // Overrun: N=2 but six pixels
      clr();
      frame(2, 6, 800, 6);
      chk("overrun_err", 32'(err_cnt), 32'd1);
      chk("overrun_ovf", 32'(ovf_cnt), 32'd2);
      chk_rd("overrun_a3", 3, 16'd804);
      chk_rd("overrun_a0", 0, 16'd801);
      release_bank();

      // Invalid sizes
      clr();
      frame(0, 3, 900, 3);
      chk("size0_err", 32'(err_cnt), 32'd1);
      chk("size0_ovf", 32'(ovf_cnt), 32'd2);
      clr();
      frame(33, 3, 900, 3);
      chk("size33_err", 32'(err_cnt), 32'd1);
      chk("size33_ovf", 32'(ovf_cnt), 32'd2);
      chk("invalid_ready", 32'(frame_ready), 32'd0);

      // Negative pixel, single-pixel frame
`ifdef FMAP_COLLECTOR_RELU_EN
      neg_exp = 16'h0000;
`else
      neg_exp = 16'hFFF9;
`endif
      clr();
      image_size = 9'd1;
      pix(-7, 1'b1, 1'b0);
      chk("n1_err", 32'(err_cnt), 32'd0);
      chk_rd("neg_pixel", 0, neg_exp);
      release_bank();

      // Reset in the middle of a frame
      frame(5, 12, 1000, 0);
      sys_rst_n = 1'b0;
      #1;
      chk_outs_zero("midreset");
      cyc(); cyc();
      chk_outs_zero("midreset_hold");
      sys_rst_n = 1'b1;
      cyc();
      clr();
      frame(5, 25, 1100, 25);
      chk("post_reset_err", 32'(err_cnt), 32'd0);
      chk("post_reset_ovf", 32'(ovf_cnt), 32'd0);
      chk("post_reset_ready", 32'(frame_ready), 32'd1);
      chk_rd("post_reset_a0", 0, 16'd1101);
      chk_rd("post_reset_a24", 24, 16'd1125);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
